// File: rtl/instruction_immediate_encoder.sv
// RV32I instruction word encoder: packs register fields and a signed immediate into R/I/S/B/U/J words,
// checks immediate range/alignment, and expands the LI pseudo-op into LUI/ADDI. Valid/ready on both sides.
module instruction_immediate_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        out_last,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_LI  = 3'd6,
    FMT_RSV = 3'd7
  } fmt_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  // ---------------------------------------------------------------------------
  // Field packers, one per base format
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] upper, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {upper, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode and range checks
  // ---------------------------------------------------------------------------
  state_t             state;
  fmt_t               fmt;
  logic               accept;
  logic signed [31:0] simm;
  logic               fits_12;
  logic               fits_b;
  logic               fits_j;
  logic [11:0]        li_lo;
  logic [19:0]        li_hi;
  logic [31:0]        first_word;
  logic [31:0]        second_word;
  logic               two_words;
  logic [1:0]         enc_err;
  logic [31:0]        pending_word;

  assign fmt  = fmt_t'(in_fmt);
  assign simm = $signed(in_imm);

  assign fits_12 = (simm >= -32'sd2048)    && (simm <= 32'sd2047);
  assign fits_b  = (simm >= -32'sd4096)    && (simm <= 32'sd4094);
  assign fits_j  = (simm >= -32'sd1048576) && (simm <= 32'sd1048574);

  // ADDI sign-extends its 12 bits, so the upper part absorbs a borrow when bit 11 is set.
  assign li_lo = in_imm[11:0];
  assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

  // A single-word request can follow a retiring word on the same edge.
  assign in_ready = rst_n & ((state == S_IDLE) | ((state == S_LAST) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    first_word  = '0;
    second_word = '0;
    two_words   = 1'b0;
    enc_err     = ERR_NONE;

    case (fmt)
      FMT_R: begin
        first_word = enc_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode);
      end
      FMT_I: begin
        if (!fits_12) enc_err = ERR_RANGE;
        else first_word = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode);
      end
      FMT_S: begin
        if (!fits_12) enc_err = ERR_RANGE;
        else first_word = enc_s(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
      end
      FMT_B: begin
        if (!fits_b)        enc_err = ERR_RANGE;
        else if (in_imm[0]) enc_err = ERR_ALIGN;
        else first_word = enc_b(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
      end
      FMT_U: begin
        if (in_imm[11:0] != 12'd0) enc_err = ERR_RANGE;
        else first_word = enc_u(in_imm[31:12], in_rd, in_opcode);
      end
      FMT_J: begin
        if (!fits_j)        enc_err = ERR_RANGE;
        else if (in_imm[0]) enc_err = ERR_ALIGN;
        else first_word = enc_j(in_imm, in_rd, in_opcode);
      end
      FMT_LI: begin
        if (li_hi == 20'd0) begin
          first_word = enc_i(li_lo, 5'd0, 3'b000, in_rd, OP_OP_IMM);
        end else if (li_lo == 12'd0) begin
          first_word = enc_u(li_hi, in_rd, OP_LUI);
        end else begin
          first_word  = enc_u(li_hi, in_rd, OP_LUI);
          second_word = enc_i(li_lo, in_rd, 3'b000, in_rd, OP_OP_IMM);
          two_words   = 1'b1;
        end
      end
      default: begin
        enc_err = ERR_FMT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_last        <= 1'b0;
      err_valid       <= 1'b0;
      err_code        <= ERR_NONE;
      pending_word    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same clock edge.
      err_valid <= 1'b0;

      if (accept) begin
        if (enc_err != ERR_NONE) begin
          err_valid <= 1'b1;
          err_code  <= enc_err;
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          out_instruction <= first_word;
          pending_word    <= second_word;
          out_valid       <= 1'b1;
          if (two_words) begin
            state    <= S_FIRST;
            out_last <= 1'b0;
          end else begin
            state    <= S_LAST;
            out_last <= 1'b1;
          end
        end
      end else if ((state == S_FIRST) && out_ready) begin
        out_instruction <= pending_word;
        out_last        <= 1'b1;
        state           <= S_LAST;
      end else if ((state == S_LAST) && out_ready) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_immediate_encoder.sv
// Scoreboard bench for instruction_immediate_encoder: expected words/errors are queued as requests are
// driven and compared on the falling edge whenever the encoder presents a word or an error pulse.
module tb_instruction_immediate_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instruction;
  logic        out_last;
  logic        err_valid;
  logic [1:0]  err_code;

  instruction_immediate_encoder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_fmt          (in_fmt),
    .in_opcode       (in_opcode),
    .in_rd           (in_rd),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_funct3       (in_funct3),
    .in_funct7       (in_funct7),
    .in_imm          (in_imm),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_last        (out_last),
    .err_valid       (err_valid),
    .err_code        (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] word;
    logic        last;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_w(input logic [31:0] word, input logic last);
    exp_t e;
    e.is_err = 1'b0;
    e.word   = word;
    e.last   = last;
    e.code   = 2'd0;
    sb.push_back(e);
  endtask

  task automatic push_e(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1;
    e.word   = '0;
    e.last   = 1'b0;
    e.code   = code;
    sb.push_back(e);
  endtask

  // Drive one request and hold it until accepted; waited counts falling edges with in_ready low.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, output int waited);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: outputs are stable across the low phase because the bench only changes inputs at posedge+1.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (err_valid) begin
        if (sb.size() == 0) begin
          check("err_unexpected", {31'd0, err_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("err_vs_word", {31'd0, err_valid}, {31'd0, e.is_err});
          check("err_code", {30'd0, err_code}, {30'd0, e.code});
          check("err_no_word", {31'd0, out_valid}, 32'd0);
        end
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("word_unexpected", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb[0];
          check("word_vs_err", {31'd0, err_valid}, {31'd0, e.is_err});
          check("word", out_instruction, e.word);
          check("last", {31'd0, out_last}, {31'd0, e.last});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int w;

    // Reset state, observed asynchronously while rst_n is low.
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instruction, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-word formats.
    push_w(32'hFFF10093, 1'b1);
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, w);
    push_w(32'h00208463, 1'b1);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, w);
    push_e(2'd2);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, w);
    push_e(2'd1);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096, w);
    push_w(32'h402081B3, 1'b1);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, w);
    push_w(32'hFE312E23, 1'b1);
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFFFFC, w);
    push_w(32'hABCDE1B7, 1'b1);
    send(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, w);
    push_e(2'd1);
    send(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000100, w);
    push_w(32'h800000EF, 1'b1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, w);
    push_e(2'd1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, w);
    push_e(2'd1);
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, w);
    drain();

    // Two-word LI with the consumer stalled; the first word must hold still.
    out_ready = 1'b0;
    push_w(32'h123462B7, 1'b0);
    push_w(32'hFFF28293, 1'b1);
    send(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, w);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Single-word LI forms.
    push_w(32'h7FF00293, 1'b1);
    send(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF, w);
    push_w(32'h000012B7, 1'b1);
    send(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, w);
    drain();

    // Back-to-back I requests must be accepted without a wait cycle, then a reserved format.
    for (int i = 0; i < 4; i++) begin
      push_w({12'(i * 16), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 1'b1);
      send(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 16), w);
      if (i > 0) check("b2b_wait", w, 32'd0);
    end
    push_e(2'd3);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, w);
    drain();
    push_w(32'h00500113, 1'b1);
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, w);
    drain();
    check("err_code_held", {30'd0, err_code}, 32'd3);

    // Reset while the LUI of a two-word LI is held: the ADDI must never appear.
    out_ready = 1'b0;
    push_w(32'h123462B7, 1'b0);
    send(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    push_w(32'hFFF10093, 1'b1);
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, w);
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
